// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer for the ARM-like datapath.
// Decodes the held instruction and checks its condition field against the internal NZCV
// register. Drives the datapath controls state by state and handshakes the shared memory.
// A memory request that waits too long halts the sequencer until reset.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        ALUSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl,
  output logic [3:0]  Flags,
  output logic        illegal,
  output logic        fault
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMADR,
    S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_HALT
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] wcnt;
  logic          set_illegal, set_fault, upd_flags, timeout_hit;

  // Instruction fields
  logic [3:0] cond, cmd;
  logic [1:0] op;
  logic       ibit, sbit, ubit, lbit;
  assign cond = Instr[31:28];
  assign op   = Instr[27:26];
  assign ibit = Instr[25];
  assign cmd  = Instr[24:21];
  assign sbit = Instr[20];
  assign ubit = Instr[23];
  assign lbit = Instr[20];

  // Offset/register fields belong to the datapath, not the sequencer
  logic unused_bits;
  assign unused_bits = ^{Instr[19:0], Instr[22]};

  // ARM condition table; 1111 never passes (flagged illegal separately)
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = cf;
      4'b0011: cond_pass = !cf;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = cf && !z;
      4'b1001: cond_pass = !cf || z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z && (n == v);
      4'b1101: cond_pass = z || (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  // Data-processing command decode
  logic       dp_legal, dp_cmp;
  logic [1:0] dp_alu;
  always_comb begin
    dp_legal = 1'b1;
    dp_cmp   = 1'b0;
    dp_alu   = 2'b00;
    case (cmd)
      4'b0100: dp_alu = 2'b00;
      4'b0010: dp_alu = 2'b01;
      4'b0000: dp_alu = 2'b10;
      4'b1100: dp_alu = 2'b11;
      4'b1010: begin dp_alu = 2'b01; dp_cmp = 1'b1; end
      default: dp_legal = 1'b0;
    endcase
  end

  assign timeout_hit = (wcnt == CW'(TIMEOUT - 1));

  // Next-state and Moore outputs; only FETCH's IR/PC strobes look at mem_ready
  always_comb begin
    state_n     = state;
    set_illegal = 1'b0;
    set_fault   = 1'b0;
    upd_flags   = 1'b0;
    mem_req     = 1'b0;
    MemWrite    = 1'b0;
    AdrSrc      = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCSrc       = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrc      = 1'b0;
    RegSrc      = 2'b00;
    ImmSrc      = 2'b00;
    ALUControl  = 2'b00;
    case (state)
      S_IDLE: state_n = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_n = S_DECODE;
        end else if (timeout_hit) begin
          set_fault = 1'b1;
          state_n   = S_HALT;
        end
      end
      S_DECODE: begin
        ImmSrc  = op;
        state_n = S_FETCH;
        if (cond == 4'b1111) begin
          set_illegal = 1'b1;
        end else if (cond_pass(cond, Flags)) begin
          case (op)
            2'b00: begin
              if (dp_legal) state_n = S_EXEC;
              else          set_illegal = 1'b1;
            end
            2'b01:   state_n = S_MEMADR;
            2'b10:   state_n = S_BRANCH;
            default: set_illegal = 1'b1;
          endcase
        end
      end
      S_EXEC: begin
        ImmSrc     = op;
        ALUSrc     = ibit;
        ALUControl = dp_alu;
        upd_flags  = sbit || dp_cmp;
        state_n    = dp_cmp ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        ImmSrc     = op;
        ALUSrc     = ibit;
        ALUControl = dp_alu;
        RegWrite   = 1'b1;
        state_n    = S_FETCH;
      end
      S_MEMADR: begin
        ImmSrc     = op;
        ALUSrc     = 1'b1;
        ALUControl = ubit ? 2'b00 : 2'b01;
        state_n    = lbit ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD, S_MEMWR: begin
        ImmSrc     = op;
        ALUSrc     = 1'b1;
        ALUControl = ubit ? 2'b00 : 2'b01;
        mem_req    = 1'b1;
        AdrSrc     = 1'b1;
        if (state == S_MEMWR) begin
          MemWrite  = 1'b1;
          RegSrc[1] = 1'b1;
        end
        if (mem_ready) begin
          state_n = (state == S_MEMRD) ? S_MEMWB : S_FETCH;
        end else if (timeout_hit) begin
          set_fault = 1'b1;
          state_n   = S_HALT;
        end
      end
      S_MEMWB: begin
        ImmSrc   = op;
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_n  = S_FETCH;
      end
      S_BRANCH: begin
        ImmSrc     = op;
        RegSrc[0]  = 1'b1;
        ALUSrc     = 1'b1;
        ALUControl = 2'b00;
        PCWrite    = 1'b1;
        PCSrc      = 1'b1;
        state_n    = S_FETCH;
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_IDLE;
    endcase
  end

  // State, flags, sticky status and memory wait counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      Flags   <= 4'b0000;
      illegal <= 1'b0;
      fault   <= 1'b0;
      wcnt    <= '0;
    end else begin
      state <= state_n;
      if (upd_flags)   Flags   <= ALUFlags;
      if (set_illegal) illegal <= 1'b1;
      if (set_fault)   fault   <= 1'b1;
      // Counts stalled request cycles; any completion or non-request state clears it
      if (mem_req && !mem_ready) wcnt <= wcnt + CW'(1);
      else                       wcnt <= '0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: expected per-cycle control vectors are queued as each
// instruction is issued, then popped and compared cycle by cycle at the falling edge.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Instr = 32'h0;
  logic [3:0]  ALUFlags = 4'h0;
  logic        mem_ready = 1'b0;
  logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, PCSrc, RegWrite, MemtoReg, ALUSrc;
  logic [1:0]  RegSrc, ImmSrc, ALUControl;
  logic [3:0]  Flags;
  logic        illegal, fault;

  int compared = 0;
  int mismatched = 0;
  logic [14:0] exq[$];

  multicycle_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ALUSrc(ALUSrc), .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .Flags(Flags), .illegal(illegal), .fault(fault)
  );

  always #5 clk = ~clk;

  logic [14:0] outs;
  assign outs = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, PCSrc, RegWrite, MemtoReg,
                 ALUSrc, RegSrc, ImmSrc, ALUControl};

  function automatic logic [14:0] mk(input logic req, mw, adr, irw, pcw, pcs, rw, m2r, asrc,
                                     input logic [1:0] rs, is, ac);
    return {req, mw, adr, irw, pcw, pcs, rw, m2r, asrc, rs, is, ac};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock: drive mem_ready, compare outputs with the oldest queued expectation
  task automatic tick(input logic rdy, input string tag);
    mem_ready = rdy;
    @(negedge clk);
    if (exq.size() == 0) chk({tag, "_noexp"}, 32'd1, 32'd0);
    else chk(tag, {17'd0, outs}, {17'd0, exq.pop_front()});
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] ins, input int waits);
    repeat (waits) begin
      exq.push_back(mk(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00));
      tick(1'b0, "fetch_wait");
    end
    Instr = ins;
    exq.push_back(mk(1,0,0,1,1,0,0,0,0,2'b00,2'b00,2'b00));
    tick(1'b1, "fetch");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  localparam logic [14:0] QUIET = 15'd0;

  initial begin
    // Reset held low for three cycles
    ALUFlags  = 4'b1111;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {17'd0, outs}, 32'd0);
    chk("rst_flags", {28'd0, Flags}, 32'd0);
    chk("rst_sticky", {30'd0, illegal, fault}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exq.push_back(QUIET);
    tick(1'b1, "idle");

    // ADD S=1 register operand: Flags take ALUFlags in EXEC
    fetch(32'hE0910002, 1);
    exq.push_back(QUIET);
    exq.push_back(QUIET);
    exq.push_back(mk(0,0,0,0,0,0,1,0,0,2'b00,2'b00,2'b00));
    tick(1'b1, "add_dec");
    ALUFlags = 4'b0100;
    tick(1'b0, "add_exec");
    ALUFlags = 4'b1011;
    tick(1'b0, "add_wb");
    chk("add_flags", {28'd0, Flags}, 32'h4);

    // SUB immediate S=0: Flags untouched
    fetch(32'hE2410001, 0);
    exq.push_back(QUIET);
    exq.push_back(mk(0,0,0,0,0,0,0,0,1,2'b00,2'b00,2'b01));
    exq.push_back(mk(0,0,0,0,0,0,1,0,1,2'b00,2'b00,2'b01));
    repeat (3) tick(1'b0, "sub_seq");
    chk("sub_flags", {28'd0, Flags}, 32'h4);

    // AND S=1 then ORR immediate
    fetch(32'hE0100000, 0);
    exq.push_back(QUIET);
    exq.push_back(mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10));
    exq.push_back(mk(0,0,0,0,0,0,1,0,0,2'b00,2'b00,2'b10));
    ALUFlags = 4'b1000;
    repeat (3) tick(1'b0, "and_seq");
    chk("and_flags", {28'd0, Flags}, 32'h8);
    fetch(32'hE3810001, 0);
    exq.push_back(QUIET);
    exq.push_back(mk(0,0,0,0,0,0,0,0,1,2'b00,2'b00,2'b11));
    exq.push_back(mk(0,0,0,0,0,0,1,0,1,2'b00,2'b00,2'b11));
    ALUFlags = 4'b0001;
    repeat (3) tick(1'b0, "orr_seq");
    chk("orr_flags", {28'd0, Flags}, 32'h8);

    // CMP: SUB with flag update and no writeback, straight back to FETCH
    fetch(32'hE1500000, 0);
    exq.push_back(QUIET);
    exq.push_back(mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b01));
    ALUFlags = 4'b0100;
    repeat (2) tick(1'b0, "cmp_seq");
    chk("cmp_flags", {28'd0, Flags}, 32'h4);

    // Z=1: BNE falls through, BEQ branches
    ALUFlags = 4'b1111;
    fetch(32'h1AFFFFFE, 0);
    exq.push_back(mk(0,0,0,0,0,0,0,0,0,2'b00,2'b10,2'b00));
    tick(1'b1, "bne_dec");
    fetch(32'h0AFFFFFE, 0);
    exq.push_back(mk(0,0,0,0,0,0,0,0,0,2'b00,2'b10,2'b00));
    exq.push_back(mk(0,0,0,0,1,1,0,0,1,2'b01,2'b10,2'b00));
    tick(1'b1, "beq_dec");
    tick(1'b0, "beq_branch");

    // LDR with three stalled cycles in MEMRD
    fetch(32'hE5910000, 0);
    exq.push_back(mk(0,0,0,0,0,0,0,0,0,2'b00,2'b01,2'b00));
    exq.push_back(mk(0,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b00));
    repeat (4) exq.push_back(mk(1,0,1,0,0,0,0,0,1,2'b00,2'b01,2'b00));
    exq.push_back(mk(0,0,0,0,0,0,1,1,0,2'b00,2'b01,2'b00));
    tick(1'b1, "ldr_dec");
    tick(1'b1, "ldr_adr");
    repeat (3) tick(1'b0, "ldr_wait");
    tick(1'b1, "ldr_rd");
    tick(1'b0, "ldr_wb");
    chk("ldr_flags", {28'd0, Flags}, 32'h4);

    // STR with U=0, zero wait, back-to-back FETCH
    fetch(32'hE5010000, 0);
    exq.push_back(mk(0,0,0,0,0,0,0,0,0,2'b00,2'b01,2'b00));
    exq.push_back(mk(0,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01));
    exq.push_back(mk(1,1,1,0,0,0,0,0,1,2'b10,2'b01,2'b01));
    tick(1'b0, "str_dec");
    tick(1'b0, "str_adr");
    tick(1'b1, "str_wr");

    // op=11 then undefined DP cmd: illegal sticky, no side effects
    chk("pre_illegal", {31'd0, illegal}, 32'd0);
    fetch(32'hEC000000, 0);
    exq.push_back(mk(0,0,0,0,0,0,0,0,0,2'b00,2'b11,2'b00));
    tick(1'b0, "op11_dec");
    chk("op11_illegal", {31'd0, illegal}, 32'd1);
    fetch(32'hE1F00000, 0);
    exq.push_back(QUIET);
    tick(1'b0, "badcmd_dec");
    chk("badcmd_illegal", {31'd0, illegal}, 32'd1);
    chk("badcmd_flags", {28'd0, Flags}, 32'h4);

    // STR never acknowledged: 16 wait cycles then HALT with fault
    fetch(32'hE5810000, 0);
    exq.push_back(mk(0,0,0,0,0,0,0,0,0,2'b00,2'b01,2'b00));
    exq.push_back(mk(0,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b00));
    repeat (16) exq.push_back(mk(1,1,1,0,0,0,0,0,1,2'b10,2'b01,2'b00));
    tick(1'b0, "to_dec");
    tick(1'b0, "to_adr");
    repeat (15) tick(1'b0, "to_wait");
    chk("to_nofault_yet", {31'd0, fault}, 32'd0);
    tick(1'b0, "to_last");
    chk("to_fault", {31'd0, fault}, 32'd1);
    repeat (3) exq.push_back(QUIET);
    repeat (3) tick(1'b1, "halt");

    // Reset clears fault and illegal
    reset = 1'b0;
    #1;
    chk("rst2_sticky", {30'd0, illegal, fault}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exq.push_back(QUIET);
    tick(1'b1, "idle2");
    exq.push_back(mk(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00));
    tick(1'b0, "fetch_wait2");

    // Reset mid-wait: request drops at once, no strobe leaks even with mem_ready high
    #2;
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("rst_midwait_outs", {17'd0, outs}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exq.push_back(QUIET);
    tick(1'b1, "idle3");
    fetch(32'hE0910002, 0);
    chk("queue_drained", exq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
